// File: rtl/operand_fetch_ctrl_pkg.sv
// rtl/operand_fetch_ctrl_pkg.sv - shared widths and FSM encoding for the operand fetch controller
package operand_fetch_ctrl_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_FETCH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/operand_fetch_ctrl_reg_scoreboard.sv
// rtl/operand_fetch_ctrl_reg_scoreboard.sv - pending-write bit per register with two hazard lookups
module reg_scoreboard
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_valid,
    input  logic [AW-1:0] set_adr,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_adr,
    input  logic [AW-1:0] look_adr1,
    input  logic [AW-1:0] look_adr2,
    output logic          busy1,
    output logic          busy2
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] pending;

    // Set is applied after clear so a same-cycle set/clear of one address leaves it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_valid) pending[clr_adr] <= 1'b0;
            if (set_valid) pending[set_adr] <= 1'b1;
        end
    end

    // A writeback landing this cycle already resolves the hazard, so mask it out of the lookup.
    always_comb begin
        busy1 = pending[look_adr1] & ~(clr_valid && (clr_adr == look_adr1));
        busy2 = pending[look_adr2] & ~(clr_valid && (clr_adr == look_adr2));
    end
endmodule

// File: rtl/operand_fetch_ctrl.sv
// rtl/operand_fetch_ctrl.sv - issue/hazard FSM driving a 2R1W register bank and handing operands downstream
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = operand_fetch_ctrl_pkg::ADDR_W,
    parameter int DATA_W = operand_fetch_ctrl_pkg::DATA_W,
    parameter int CNT_W  = operand_fetch_ctrl_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_src1,
    input  logic [ADDR_W-1:0] issue_src2,
    input  logic              issue_use1,
    input  logic              issue_use2,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              issue_wdst,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_dst,
    output logic              op_wdst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_read1,
    output logic              rf_read2,
    output logic [ADDR_W-1:0] rf_adr1,
    output logic [ADDR_W-1:0] rf_adr2,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_adrW,
    output logic [DATA_W-1:0] rf_din,
    output logic [CNT_W-1:0]  stall_cnt
);
    state_t            state;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic              use1_q;
    logic              use2_q;
    logic [ADDR_W-1:0] look_adr1;
    logic [ADDR_W-1:0] look_adr2;
    logic              look_use1;
    logic              look_use2;
    logic              busy1;
    logic              busy2;
    logic              hazard;
    logic              sb_set;
    logic              byp1;
    logic              byp2;

    assign rf_write = wb_valid;
    assign rf_adrW  = wb_adr;
    assign rf_din   = wb_data;

    // In IDLE the hazard is judged on the incoming request, in STALL on the latched one.
    always_comb begin
        look_adr1 = (state == S_IDLE) ? issue_src1 : src1_q;
        look_adr2 = (state == S_IDLE) ? issue_src2 : src2_q;
        look_use1 = (state == S_IDLE) ? issue_use1 : use1_q;
        look_use2 = (state == S_IDLE) ? issue_use2 : use2_q;
        hazard    = (look_use1 & busy1) | (look_use2 & busy2);
        sb_set    = (state == S_HOLD) & op_ready & op_wdst;
        byp1      = wb_valid & (wb_adr == src1_q) & use1_q;
        byp2      = wb_valid & (wb_adr == src2_q) & use2_q;
    end

    reg_scoreboard #(.AW(ADDR_W)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (sb_set),
        .set_adr   (op_dst),
        .clr_valid (wb_valid),
        .clr_adr   (wb_adr),
        .look_adr1 (look_adr1),
        .look_adr2 (look_adr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            issue_ready <= 1'b1;
            src1_q      <= '0;
            src2_q      <= '0;
            use1_q      <= 1'b0;
            use2_q      <= 1'b0;
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_dst      <= '0;
            op_wdst     <= 1'b0;
            rf_read1    <= 1'b0;
            rf_read2    <= 1'b0;
            rf_adr1     <= '0;
            rf_adr2     <= '0;
            stall_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_valid) begin
                        src1_q      <= issue_src1;
                        src2_q      <= issue_src2;
                        use1_q      <= issue_use1;
                        use2_q      <= issue_use2;
                        op_dst      <= issue_dst;
                        op_wdst     <= issue_wdst;
                        issue_ready <= 1'b0;
                        if (hazard) begin
                            state <= S_STALL;
                        end else begin
                            state    <= S_FETCH;
                            rf_read1 <= issue_use1;
                            rf_read2 <= issue_use2;
                            rf_adr1  <= issue_use1 ? issue_src1 : '0;
                            rf_adr2  <= issue_use2 ? issue_src2 : '0;
                        end
                    end
                end
                S_STALL: begin
                    if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                    if (!hazard) begin
                        state    <= S_FETCH;
                        rf_read1 <= use1_q;
                        rf_read2 <= use2_q;
                        rf_adr1  <= use1_q ? src1_q : '0;
                        rf_adr2  <= use2_q ? src2_q : '0;
                    end
                end
                S_FETCH: begin
                    // A writeback to a source in this cycle beats whatever the bank returns.
                    op_a     <= !use1_q ? '0 : (byp1 ? wb_data : rf_dout1);
                    op_b     <= !use2_q ? '0 : (byp2 ? wb_data : rf_dout2);
                    op_valid <= 1'b1;
                    rf_read1 <= 1'b0;
                    rf_read2 <= 1'b0;
                    rf_adr1  <= '0;
                    rf_adr2  <= '0;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (op_ready) begin
                        op_valid    <= 1'b0;
                        issue_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    issue_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb/tb_operand_fetch_ctrl.sv - directed scoreboard bench for operand_fetch_ctrl with a behavioural bank
module tb_operand_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_src1, issue_src2, issue_dst;
    logic        issue_use1, issue_use2, issue_wdst;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;
    logic [6:0]  op_dst;
    logic        op_wdst;
    logic        wb_valid;
    logic [6:0]  wb_adr;
    logic [15:0] wb_data;
    logic        rf_read1, rf_read2;
    logic [6:0]  rf_adr1, rf_adr2;
    logic [15:0] rf_dout1, rf_dout2;
    logic        rf_write;
    logic [6:0]  rf_adrW;
    logic [15:0] rf_din;
    logic [15:0] stall_cnt;

    logic [15:0] bank [0:127];
    logic [31:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (rf_write) bank[rf_adrW] <= rf_din;
    assign rf_dout1 = rf_read1 ? bank[rf_adr1] : 16'hzzzz;
    assign rf_dout2 = rf_read2 ? bank[rf_adr2] : 16'hzzzz;

    operand_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_use1(issue_use1), .issue_use2(issue_use2),
        .issue_dst(issue_dst), .issue_wdst(issue_wdst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_dst(op_dst), .op_wdst(op_wdst),
        .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_adr1(rf_adr1), .rf_adr2(rf_adr2),
        .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
        .rf_write(rf_write), .rf_adrW(rf_adrW), .rf_din(rf_din),
        .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] s1, input logic [6:0] s2, input logic u1,
                         input logic u2, input logic [6:0] d, input logic w);
        issue_valid = 1'b1;
        issue_src1  = s1;
        issue_src2  = s2;
        issue_use1  = u1;
        issue_use2  = u2;
        issue_dst   = d;
        issue_wdst  = w;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wait_op(input string tag);
        logic [31:0] e;
        int n = 0;
        while (!op_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, op_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_op_a"}, {16'd0, op_a}, {16'd0, e[31:16]});
            chk({tag, "_op_b"}, {16'd0, op_b}, {16'd0, e[15:0]});
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) bank[i] = 16'h0;
        bank[5]  = 16'h1234;
        bank[6]  = 16'hBEEF;
        bank[11] = 16'h0B0B;
        rst = 1'b1;
        issue_valid = 0; issue_src1 = 0; issue_src2 = 0; issue_use1 = 0; issue_use2 = 0;
        issue_dst = 0; issue_wdst = 0; op_ready = 0; wb_valid = 0; wb_adr = 0; wb_data = 0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_op_a", {16'd0, op_a}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_rf_read1", {31'd0, rf_read1}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);

        // 1: plain fetch, read enables one cycle, 2-cycle latency
        exp_q.push_back({16'h1234, 16'hBEEF});
        issue(7'd5, 7'd6, 1'b1, 1'b1, 7'd0, 1'b0);
        chk("t1_rf_read1", {31'd0, rf_read1}, 32'd1);
        chk("t1_rf_read2", {31'd0, rf_read2}, 32'd1);
        chk("t1_rf_adr1", {25'd0, rf_adr1}, 32'd5);
        chk("t1_valid_early", {31'd0, op_valid}, 32'd0);
        step();
        chk("t1_valid_lat2", {31'd0, op_valid}, 32'd1);
        chk("t1_rf_read1_off", {31'd0, rf_read1}, 32'd0);
        wait_op("t1");
        chk("t1_idle_again", {31'd0, issue_ready}, 32'd1);

        // 2: write-after dependency stalls until writeback
        exp_q.push_back({16'h0, 16'h0});
        issue(7'd0, 7'd0, 1'b0, 1'b0, 7'd9, 1'b1);
        wait_op("t2a");
        exp_q.push_back({16'h00AA, 16'h0});
        issue(7'd9, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0);
        chk("t2_stall_ready", {31'd0, issue_ready}, 32'd0);
        chk("t2_stall_noread", {31'd0, rf_read1}, 32'd0);
        step();
        step();
        chk("t2_stall_cnt2", {16'd0, stall_cnt}, 32'd2);
        wb_valid = 1'b1; wb_adr = 7'd9; wb_data = 16'h00AA;
        step();
        wb_valid = 1'b0;
        chk("t2_fetch_read1", {31'd0, rf_read1}, 32'd1);
        chk("t2_stall_cnt3", {16'd0, stall_cnt}, 32'd3);
        wait_op("t2b");

        // 3: bypass of a same-cycle writeback during FETCH
        exp_q.push_back({16'h1234, 16'h5555});
        issue(7'd5, 7'd7, 1'b1, 1'b1, 7'd0, 1'b0);
        wb_valid = 1'b1; wb_adr = 7'd7; wb_data = 16'h5555;
        step();
        wb_valid = 1'b0;
        wait_op("t3");
        chk("t3_bank_r7", {16'd0, bank[7]}, 32'h5555);

        // src1 == src2
        exp_q.push_back({16'hBEEF, 16'hBEEF});
        issue(7'd6, 7'd6, 1'b1, 1'b1, 7'd0, 1'b0);
        chk("t3s_same_adr2", {25'd0, rf_adr2}, 32'd6);
        wait_op("t3s");

        // 4: backpressure keeps operands stable, new issue ignored
        issue(7'd6, 7'd5, 1'b1, 1'b1, 7'd0, 1'b0);
        step();
        issue_valid = 1'b1;
        issue_src1 = 7'd5;
        for (int k = 0; k < 4; k++) begin
            chk("t4_hold_valid", {31'd0, op_valid}, 32'd1);
            chk("t4_hold_a", {16'd0, op_a}, 32'hBEEF);
            chk("t4_hold_b", {16'd0, op_b}, 32'h1234);
            chk("t4_hold_ready", {31'd0, issue_ready}, 32'd0);
            step();
        end
        issue_valid = 1'b0;
        exp_q.push_back({16'hBEEF, 16'h1234});
        wait_op("t4");

        // 5: async reset during STALL
        exp_q.push_back({16'h0, 16'h0});
        issue(7'd0, 7'd0, 1'b0, 1'b0, 7'd11, 1'b1);
        wait_op("t5a");
        issue(7'd11, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0);
        step();
        chk("t5_in_stall", {31'd0, issue_ready}, 32'd0);
        rst = 1'b1;
        #2;
        chk("t5_rst_valid", {31'd0, op_valid}, 32'd0);
        chk("t5_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("t5_rst_ready", {31'd0, issue_ready}, 32'd1);
        step();
        rst = 1'b0;
        step();
        exp_q.push_back({16'h0B0B, 16'h0});
        issue(7'd11, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0);
        chk("t5_no_stall", {31'd0, rf_read1}, 32'd1);
        wait_op("t5b");

        // 6: set wins over same-cycle clear
        issue(7'd0, 7'd0, 1'b0, 1'b0, 7'd3, 1'b1);
        step();
        chk("t6_hold", {31'd0, op_valid}, 32'd1);
        op_ready = 1'b1;
        wb_valid = 1'b1; wb_adr = 7'd3; wb_data = 16'h0303;
        step();
        op_ready = 1'b0;
        wb_valid = 1'b0;
        exp_q.push_back({16'h3333, 16'h0});
        issue(7'd3, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0);
        chk("t6_stalls", {31'd0, rf_read1}, 32'd0);
        step();
        step();
        chk("t6_stall_cnt", {16'd0, stall_cnt}, 32'd2);
        wb_valid = 1'b1; wb_adr = 7'd3; wb_data = 16'h3333;
        step();
        wb_valid = 1'b0;
        wait_op("t6");
        chk("t6_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
